// File: rtl/ri_ctrl_pkg.sv
// ri_ctrl_pkg: opcodes, ALU operation codes and FSM states shared by the R/I-type controller
package ri_ctrl_pkg;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [5:0] F6_SRA = 6'b010000;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
endpackage

// File: rtl/ri_decoder.sv
// ri_decoder: combinational RV64I R/I-type ALU instruction decoder
module ri_decoder
  import ri_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  rs1,
  output logic [5:0]  rs2,
  output logic [5:0]  rd,
  output logic [11:0] imm,
  output logic [3:0]  alu_co,
  output logic        alu_src,
  output logic        legal,
  output logic        add_sub
);
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;
  logic is_r, is_i, base_ok, alt;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign f6 = instr[31:26];
  assign is_r = op == OP_R;
  assign is_i = op == OP_I;
  assign base_ok = is_i || (is_r && f7 == F7_BASE);
  assign alt = is_r ? f7 == F7_ALT : f6 == F6_SRA;
  assign rs1 = {1'b0, instr[19:15]};
  assign rs2 = is_i ? 6'd0 : {1'b0, instr[24:20]};
  assign rd = {1'b0, instr[11:7]};
  assign alu_src = is_i;
  assign imm = is_r ? 12'd0 : (f3 == 3'b001 || f3 == 3'b101) ? {6'd0, instr[25:20]} : instr[31:20];
  assign add_sub = legal && f3 == 3'b000;
  // operation code and legality per funct3, with funct7/funct6 qualifying sub, sra and the shifts
  always_comb begin
    alu_co = ALU_ADD;
    legal = 1'b0;
    case (f3)
      3'b000: begin
        alu_co = (is_r && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        legal = base_ok || (is_r && f7 == F7_ALT);
      end
      3'b001: begin
        alu_co = ALU_SLL;
        legal = is_r ? f7 == F7_BASE : is_i && f6 == 6'd0;
      end
      3'b010: begin
        alu_co = ALU_SLT;
        legal = base_ok;
      end
      3'b100: begin
        alu_co = ALU_XOR;
        legal = base_ok;
      end
      3'b101: begin
        alu_co = alt ? ALU_SRA : ALU_SRL;
        legal = is_r ? (f7 == F7_BASE || alt) : is_i && (f6 == 6'd0 || alt);
      end
      3'b110: begin
        alu_co = ALU_OR;
        legal = base_ok;
      end
      3'b111: begin
        alu_co = ALU_AND;
        legal = base_ok;
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/ri_multicycle_ctrl.sv
// ri_multicycle_ctrl: four-phase controller sequencing one R/I-type ALU instruction at a time
module ri_multicycle_ctrl
  import ri_ctrl_pkg::*;
#(
  parameter int RET_W = 16,
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             overflow,
  output logic [5:0]       register_1,
  output logic [5:0]       register_2,
  output logic [5:0]       write_register,
  output logic [11:0]      imm,
  output logic             ALUSrc,
  output logic [3:0]       ALU_CO,
  output logic             RegWrite,
  output logic             done,
  output logic             illegal,
  output logic [RET_W-1:0] retired_count,
  output logic [OVF_W-1:0] ovf_count
);
  state_t state, state_n;
  logic [31:0] instr_q;
  logic add_sub_q;
  logic [5:0] d_rs1, d_rs2, d_rd;
  logic [11:0] d_imm;
  logic [3:0] d_alu_co;
  logic d_alu_src, d_legal, d_add_sub;
  ri_decoder u_dec (
    .instr(instr_q),
    .rs1(d_rs1),
    .rs2(d_rs2),
    .rd(d_rd),
    .imm(d_imm),
    .alu_co(d_alu_co),
    .alu_src(d_alu_src),
    .legal(d_legal),
    .add_sub(d_add_sub)
  );
  assign instr_ready = state == IDLE && !reset;
  assign RegWrite = state == WRITEBACK && write_register != 6'd0;
  assign done = state == WRITEBACK;
  assign illegal = state == DECODE && !d_legal;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // phase sequencing; illegal words drop straight back to IDLE from DECODE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (instr_valid && instr_ready) ? DECODE : IDLE;
      DECODE: state_n = d_legal ? EXECUTE : IDLE;
      EXECUTE: state_n = WRITEBACK;
      default: state_n = IDLE;
    endcase
  end
  // capture the instruction word on the accept edge
  always_ff @(posedge clk or posedge reset)
    if (reset) instr_q <= '0;
    else if (instr_valid && instr_ready) instr_q <= instr;
  // datapath controls are loaded only for legal words and held otherwise
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      register_1 <= '0;
      register_2 <= '0;
      write_register <= '0;
      imm <= '0;
      ALUSrc <= 1'b0;
      ALU_CO <= ALU_ADD;
      add_sub_q <= 1'b0;
    end else if (state == DECODE && d_legal) begin
      register_1 <= d_rs1;
      register_2 <= d_rs2;
      write_register <= d_rd;
      imm <= d_imm;
      ALUSrc <= d_alu_src;
      ALU_CO <= d_alu_co;
      add_sub_q <= d_add_sub;
    end
  // saturating add/sub overflow count sampled in EXECUTE, wrapping retire count in WRITEBACK
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ovf_count <= '0;
      retired_count <= '0;
    end else begin
      if (state == EXECUTE && add_sub_q && overflow && ovf_count != '1) ovf_count <= ovf_count + OVF_W'(1);
      if (state == WRITEBACK) retired_count <= retired_count + RET_W'(1);
    end
endmodule

// File: tb/tb_ri_multicycle_ctrl.sv
// tb_ri_multicycle_ctrl: table-driven check of the multicycle R/I-type controller
module tb_ri_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instr = '0;
  logic instr_valid = 1'b0;
  logic overflow = 1'b0;
  logic instr_ready, ALUSrc, RegWrite, done, illegal;
  logic [5:0] register_1, register_2, write_register;
  logic [11:0] imm;
  logic [3:0] ALU_CO;
  logic [15:0] retired_count;
  logic [7:0] ovf_count;
  ri_multicycle_ctrl dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .overflow(overflow),
    .register_1(register_1),
    .register_2(register_2),
    .write_register(write_register),
    .imm(imm),
    .ALUSrc(ALUSrc),
    .ALU_CO(ALU_CO),
    .RegWrite(RegWrite),
    .done(done),
    .illegal(illegal),
    .retired_count(retired_count),
    .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] ins;
    logic ovf;
    logic lg;
    logic as;
    logic [5:0] r1;
    logic [5:0] r2;
    logic [5:0] rd;
    logic [11:0] imm;
    logic [3:0] co;
    logic src;
    logic rw;
  } vec_t;
  vec_t vecs[17];
  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;
  int exp_ovf = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_ready();
    int k = 0;
    while (instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(instr_ready), 32'd1);
  endtask
  task automatic run_vec(input vec_t v);
    wait_ready();
    instr = v.ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("illegal_dec", 32'(illegal), 32'(!v.lg));
    chk("ready_dec", 32'(instr_ready), 32'd0);
    chk("regwrite_dec", 32'(RegWrite), 32'd0);
    if (!v.lg) begin
      @(negedge clk);
      chk("illegal_after", 32'(illegal), 32'd0);
      chk("ready_after_illegal", 32'(instr_ready), 32'd1);
      chk("retired_illegal", 32'(retired_count), 32'(exp_ret));
      chk("ovf_illegal", 32'(ovf_count), 32'(exp_ovf));
    end else begin
      @(negedge clk);
      overflow = v.ovf;
      chk("register_1", 32'(register_1), 32'(v.r1));
      chk("register_2", 32'(register_2), 32'(v.r2));
      chk("write_register", 32'(write_register), 32'(v.rd));
      chk("imm", 32'(imm), 32'(v.imm));
      chk("ALU_CO", 32'(ALU_CO), 32'(v.co));
      chk("ALUSrc", 32'(ALUSrc), 32'(v.src));
      chk("regwrite_exe", 32'(RegWrite), 32'd0);
      chk("done_exe", 32'(done), 32'd0);
      @(negedge clk);
      overflow = 1'b0;
      chk("regwrite_wb", 32'(RegWrite), 32'(v.rw));
      chk("done_wb", 32'(done), 32'd1);
      if (v.as && v.ovf && exp_ovf < 255) exp_ovf++;
      exp_ret = (exp_ret + 1) & 16'hFFFF;
      @(negedge clk);
      chk("ready_idle", 32'(instr_ready), 32'd1);
      chk("done_idle", 32'(done), 32'd0);
      chk("retired", 32'(retired_count), 32'(exp_ret));
      chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
    end
  endtask
  task automatic start_add();
    wait_ready();
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd0);
    chk({tag, "_r1"}, 32'(register_1), 32'd0);
    chk({tag, "_r2"}, 32'(register_2), 32'd0);
    chk({tag, "_rd"}, 32'(write_register), 32'd0);
    chk({tag, "_imm"}, 32'(imm), 32'd0);
    chk({tag, "_alusrc"}, 32'(ALUSrc), 32'd0);
    chk({tag, "_aluco"}, 32'(ALU_CO), 32'd2);
    chk({tag, "_retired"}, 32'(retired_count), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_count), 32'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    //            ins          ovf  lg   as   r1     r2     rd     imm       co       src  rw
    vecs[0]  = '{32'h002081B3, 1'b0, 1'b1, 1'b1, 6'd1,  6'd2,  6'd3,  12'h000, 4'b0010, 1'b0, 1'b1};
    vecs[1]  = '{32'hFFF00293, 1'b1, 1'b1, 1'b1, 6'd0,  6'd0,  6'd5,  12'hFFF, 4'b0010, 1'b1, 1'b1};
    vecs[2]  = '{32'h40325213, 1'b0, 1'b1, 1'b0, 6'd4,  6'd0,  6'd4,  12'h003, 4'b1000, 1'b1, 1'b1};
    vecs[3]  = '{32'h0020B1B3, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  12'h000, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{32'h40838333, 1'b1, 1'b1, 1'b1, 6'd7,  6'd8,  6'd6,  12'h000, 4'b0110, 1'b0, 1'b1};
    vecs[5]  = '{32'h403150B3, 1'b0, 1'b1, 1'b0, 6'd2,  6'd3,  6'd1,  12'h000, 4'b1000, 1'b0, 1'b1};
    vecs[6]  = '{32'h03F51493, 1'b0, 1'b1, 1'b0, 6'd10, 6'd0,  6'd9,  12'h03F, 4'b0100, 1'b1, 1'b1};
    vecs[7]  = '{32'h8001C113, 1'b0, 1'b1, 1'b0, 6'd3,  6'd0,  6'd2,  12'h800, 4'b0011, 1'b1, 1'b1};
    vecs[8]  = '{32'h01DF7FB3, 1'b0, 1'b1, 1'b0, 6'd30, 6'd29, 6'd31, 12'h000, 4'b0000, 1'b0, 1'b1};
    vecs[9]  = '{32'h07F51493, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  12'h000, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{32'h002081BB, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  12'h000, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{32'h022081B3, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  12'h000, 4'b0000, 1'b0, 1'b0};
    vecs[12] = '{32'h7FF46393, 1'b0, 1'b1, 1'b0, 6'd8,  6'd0,  6'd7,  12'h7FF, 4'b0001, 1'b1, 1'b1};
    vecs[13] = '{32'h00535293, 1'b1, 1'b1, 1'b0, 6'd6,  6'd0,  6'd5,  12'h005, 4'b0101, 1'b1, 1'b1};
    vecs[14] = '{32'h003120B3, 1'b1, 1'b1, 1'b0, 6'd2,  6'd3,  6'd1,  12'h000, 4'b0111, 1'b0, 1'b1};
    vecs[15] = '{32'h00208033, 1'b1, 1'b1, 1'b1, 6'd1,  6'd2,  6'd0,  12'h000, 4'b0010, 1'b0, 1'b0};
    vecs[16] = '{32'h0000B013, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  12'h000, 4'b0000, 1'b0, 1'b0};
    @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 17; i++) run_vec(vecs[i]);
    for (int i = 0; i < 300; i++) run_vec(vecs[15]);
    chk("ovf_saturated", 32'(ovf_count), 32'd255);
    wait_ready();
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_ready", 32'(instr_ready), 32'((i % 4) == 0));
      if (i == 15) instr_valid = 1'b0;
      @(negedge clk);
    end
    exp_ret = (exp_ret + 4) & 16'hFFFF;
    chk("b2b_retired", 32'(retired_count), 32'(exp_ret));
    start_add();
    chk("exe_r1_before_reset", 32'(register_1), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_exe");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_exe_ready", 32'(instr_ready), 32'd1);
    chk("rst_exe_retired", 32'(retired_count), 32'd0);
    chk("rst_exe_regwrite", 32'(RegWrite), 32'd0);
    start_add();
    @(negedge clk);
    chk("wb_regwrite_before_reset", 32'(RegWrite), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_wb");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_retired", 32'(retired_count), 32'd0);
    chk("rst_wb_ready", 32'(instr_ready), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
